// File: rtl/crc32_engine.sv
// Byte-serial CRC-32 engine: accepts a 1-4 byte word, folds one byte per clock
// into a reflected CRC register, and reports the running CRC and byte count.
`timescale 1ns/1ps

module crc32_engine #(
  parameter logic [31:0] POLY   = 32'hEDB88320,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic        EXTS_HCLK,
  input  logic        EXTS_HRSTN,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_len,
  output logic [31:0] result,
  output logic        busy,
  output logic [15:0] byte_count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [31:0] crc;
  logic [31:0] shift;
  logic [2:0]  remaining;

  // One byte through the reflected polynomial; the loop unrolls into 8 stages.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    return c;
  endfunction

  assign in_ready = EXTS_HRSTN && !clear && (state == IDLE);
  assign busy     = (state == RUN);
  assign result   = crc ^ XOROUT;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge EXTS_HCLK) begin
    if (!EXTS_HRSTN || clear) begin
      state      <= IDLE;
      crc        <= INIT;
      byte_count <= '0;
      shift      <= '0;
      remaining  <= '0;
    end else begin
      case (state)
        // Reset and clear are already excluded here, so in_valid alone is the handshake.
        IDLE: if (in_valid) begin
          shift     <= in_data;
          remaining <= (in_len == 2'b00) ? 3'd4 : {1'b0, in_len};
          state     <= RUN;
        end
        RUN: begin
          crc        <= crc_byte(crc, shift[7:0]);
          shift      <= shift >> 8;
          remaining  <= remaining - 3'd1;
          byte_count <= byte_count + 16'd1;
          if (remaining == 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_engine.sv
// Self-checking bench for crc32_engine: a byte-queue CRC model checked every
// cycle, directed scenarios with known CRC values, then randomized traffic.
`timescale 1ns/1ps

module tb_crc32_engine;

  localparam logic [31:0] POLY   = 32'hEDB88320;
  localparam logic [31:0] INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] XOROUT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_len = '0;
  logic        in_ready;
  logic [31:0] result;
  logic        busy;
  logic [15:0] byte_count;

  always #5 clk = ~clk;

  crc32_engine #(.POLY(POLY), .INIT(INIT), .XOROUT(XOROUT)) dut (
    .EXTS_HCLK (clk),
    .EXTS_HRSTN(rstn),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .result    (result),
    .busy      (busy),
    .byte_count(byte_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: bit-at-a-time reflected CRC over a queue of pending bytes.
  function automatic logic [31:0] crc_update(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  logic [31:0] m_crc = INIT;
  int          m_count = 0;
  logic [7:0]  m_q[$];

  always @(posedge clk) begin : model
    int n;
    if (!rstn || clear) begin
      m_crc   = INIT;
      m_count = 0;
      m_q.delete();
    end else if (m_q.size() > 0) begin
      m_crc   = crc_update(m_crc, m_q.pop_front());
      m_count = (m_count + 1) % 65536;
    end else if (in_valid) begin
      n = (in_len == 2'b00) ? 4 : int'(in_len);
      for (int k = 0; k < n; k++) m_q.push_back(in_data[8*k +: 8]);
    end
  end

  always @(negedge clk) begin : compare
    logic idle;
    idle = (m_q.size() == 0);
    check("busy", 32'(busy), 32'(!idle));
    check("in_ready", 32'(in_ready), 32'(rstn && !clear && idle));
    check("byte_count", 32'(byte_count), 32'(m_count));
    if (idle) check("result", result, m_crc ^ XOROUT);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Offer a word until accepted; leaves in_valid high when keep_valid is set.
  task automatic send(input logic [31:0] d, input logic [1:0] l, input bit keep_valid);
    logic r;
    r = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      r = in_ready;
      tick();
      if (r) break;
    end
    n_checks++;
    if (r) n_pass++;
    else $display("FAIL accept_timeout: word %h never accepted (t=%0t)", d, $time);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Returns at a falling edge where busy is low, with the number of busy cycles seen.
  task automatic wait_idle(output int busy_cycles);
    logic done;
    done = 1'b0;
    busy_cycles = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      busy_cycles++;
    end
    n_checks++;
    if (done) n_pass++;
    else $display("FAIL idle_timeout: busy still %b (t=%0t)", busy, $time);
  endtask

  initial begin
    int bc;

    // Reset held low: in_ready must stay low.
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check("rst_result", result, 32'h00000000);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_byte_count", 32'(byte_count), 32'd0);
    tick();

    // All-zero word.
    send(32'h00000000, 2'b00, 1'b0);
    wait_idle(bc);
    check("zero_busy_cycles", 32'(bc), 32'd4);
    check("zero_result", result, 32'h2144DF1C);
    check("zero_model_pin", m_crc ^ XOROUT, 32'h2144DF1C);
    check("zero_byte_count", 32'(byte_count), 32'd4);
    tick();

    // "123456789" with in_valid held high across words.
    do_clear();
    send(32'h34333231, 2'b00, 1'b1);
    send(32'h38373635, 2'b00, 1'b1);
    send(32'h00000039, 2'b01, 1'b0);
    wait_idle(bc);
    check("check_result", result, 32'hCBF43926);
    check("check_model_pin", m_crc ^ XOROUT, 32'hCBF43926);
    check("check_byte_count", 32'(byte_count), 32'd9);
    tick();

    // Single byte 'a'; upper bytes must be ignored.
    do_clear();
    send(32'hFFFFFF61, 2'b01, 1'b0);
    wait_idle(bc);
    check("a_busy_cycles", 32'(bc), 32'd1);
    check("a_result", result, 32'hE8B7BE43);
    tick();

    // Clear on the second RUN cycle with a competing word offered.
    do_clear();
    send(32'h00000000, 2'b00, 1'b0);
    tick();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hA5A5A5A5;
    in_len   = 2'b00;
    @(negedge clk);
    check("clr_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_result", result, 32'h00000000);
    check("clr_byte_count", 32'(byte_count), 32'd0);
    tick();
    @(negedge clk);
    check("clr_not_accepted", 32'(busy), 32'd0);
    tick();
    send(32'h00000000, 2'b00, 1'b0);
    wait_idle(bc);
    check("clr_resend_result", result, 32'h2144DF1C);
    tick();

    // Reset pulled low mid-RUN for one edge.
    send(32'h11223344, 2'b00, 1'b0);
    tick();
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check("mid_rst_result", result, 32'h00000000);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_byte_count", 32'(byte_count), 32'd0);
    check("mid_rst_in_ready_high", 32'(in_ready), 32'd1);
    tick();

    // Randomized traffic, clears and resets; the compare process checks every cycle.
    for (int i = 0; i < 300; i++) begin
      int act;
      act = $urandom_range(0, 99);
      if (act < 4) begin
        do_clear();
      end else if (act < 6) begin
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
      end else begin
        send($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 9) == 0) begin
          tick();
          do_clear();
        end
      end
      repeat ($urandom_range(0, 2)) begin
        in_data = $urandom;
        in_len  = 2'($urandom_range(0, 3));
        tick();
      end
    end
    in_valid = 1'b0;
    wait_idle(bc);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
